// File: rtl/jpeg_bitstream_reader.sv
// rtl/jpeg_bitstream_reader.sv - JPEG entropy bitstream reader with byte unstuffing and marker detection
module jpeg_bitstream_reader (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] peek_bits,
    output logic [5:0]  bits_avail,
    input  logic        consume_en,
    input  logic [4:0]  consume_len,
    input  logic        marker_clear,
    output logic        marker_found,
    output logic [7:0]  marker_code,
    output logic        underflow
);

    typedef enum logic [1:0] {RUN, FF_SEEN, MARKER} state_t;

    state_t      state, state_n;
    logic [31:0] bit_buf, bit_buf_n, shifted;
    logic [5:0]  count, count_n, remain;
    logic        found_n, uf_n, append, accept, len_ok, clear;
    logic [7:0]  code_n, append_byte;

    assign byte_ready = (count <= 6'd24) && (state != MARKER) && !reset;
    assign accept     = byte_valid && byte_ready;
    assign len_ok     = ({1'b0, consume_len} <= count) && (consume_len <= 5'd16);
    assign clear      = marker_clear && (state == MARKER);
    assign peek_bits  = bit_buf[31:16];
    assign bits_avail = count;

    always_comb begin
        state_n     = state;
        bit_buf_n   = bit_buf;
        count_n     = count;
        found_n     = marker_found;
        code_n      = marker_code;
        uf_n        = underflow;
        shifted     = bit_buf;
        remain      = count;
        append      = 1'b0;
        append_byte = byte_in;
        if (clear) begin
            // Acknowledging a marker flushes the buffer and overrides any consume.
            state_n   = RUN;
            bit_buf_n = 32'h0;
            count_n   = 6'd0;
            found_n   = 1'b0;
        end else begin
            if (consume_en) begin
                if (len_ok) begin
                    shifted = bit_buf << consume_len;
                    remain  = count - {1'b0, consume_len};
                end else begin
                    uf_n = 1'b1;
                end
            end
            if (accept) begin
                unique case (state)
                    RUN: begin
                        if (byte_in == 8'hFF) state_n = FF_SEEN;
                        else                  append  = 1'b1;
                    end
                    FF_SEEN: begin
                        if (byte_in == 8'h00) begin
                            append      = 1'b1;
                            append_byte = 8'hFF;
                            state_n     = RUN;
                        end else if (byte_in != 8'hFF) begin
                            code_n  = byte_in;
                            found_n = 1'b1;
                            state_n = MARKER;
                        end
                    end
                    default: ;
                endcase
            end
            // New byte lands directly after the bits left over from any shift.
            bit_buf_n = append ? (shifted | ({append_byte, 24'h0} >> remain)) : shifted;
            count_n   = append ? (remain + 6'd8) : remain;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            bit_buf      <= 32'h0;
            count        <= 6'd0;
            marker_found <= 1'b0;
            marker_code  <= 8'h00;
            underflow    <= 1'b0;
        end else begin
            state        <= state_n;
            bit_buf      <= bit_buf_n;
            count        <= count_n;
            marker_found <= found_n;
            marker_code  <= code_n;
            underflow    <= uf_n;
        end
    end

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// tb/tb_jpeg_bitstream_reader.sv - scoreboard bench for jpeg_bitstream_reader
module tb_jpeg_bitstream_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] peek_bits;
    logic [5:0]  bits_avail;
    logic        consume_en;
    logic [4:0]  consume_len;
    logic        marker_clear;
    logic        marker_found;
    logic [7:0]  marker_code;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] peek;
        logic [5:0]  avail;
        logic        found;
        logic [7:0]  code;
        logic        uf;
        logic        ready;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    string name_q[$];

    jpeg_bitstream_reader dut (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .peek_bits(peek_bits), .bits_avail(bits_avail),
        .consume_en(consume_en), .consume_len(consume_len), .marker_clear(marker_clear),
        .marker_found(marker_found), .marker_code(marker_code), .underflow(underflow)
    );

    always #5 clock = ~clock;

    function automatic snap_t mk(input logic [15:0] p, input logic [5:0] a, input logic f,
                                 input logic [7:0] c, input logic u, input logic r);
        snap_t s;
        s.peek = p; s.avail = a; s.found = f; s.code = c; s.uf = u; s.ready = r;
        return s;
    endfunction

    task automatic tick(input string nm, input snap_t e);
        snap_t o;
        name_q.push_back(nm);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        o.peek = peek_bits; o.avail = bits_avail; o.found = marker_found;
        o.code = marker_code; o.uf = underflow; o.ready = byte_ready;
        obs_q.push_back(o);
        byte_valid = 1'b0; byte_in = 8'h00; consume_en = 1'b0; consume_len = 5'd0;
        marker_clear = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input string nm, input snap_t e);
        byte_valid = 1'b1;
        byte_in    = b;
        tick(nm, e);
    endtask

    task automatic eat(input logic [4:0] len, input string nm, input snap_t e);
        consume_en  = 1'b1;
        consume_len = len;
        tick(nm, e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick("reset_pulse", mk(16'h0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        reset = 1'b0;
    endtask

    task automatic test_reset();
        snap_t e, o; string nm;
        do_reset();
        tick("reset_idle", mk(16'h0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_basic();
        snap_t e, o; string nm;
        do_reset();
        put(8'hA5, "basic_a5", mk(16'hA500, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h3C, "basic_3c", mk(16'hA53C, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        eat(5'd4, "basic_consume4", mk(16'h53C0, 6'd12, 1'b0, 8'h00, 1'b0, 1'b1));
        eat(5'd0, "basic_consume0", mk(16'h53C0, 6'd12, 1'b0, 8'h00, 1'b0, 1'b1));
        marker_clear = 1'b1;
        tick("basic_clear_in_run", mk(16'h53C0, 6'd12, 1'b0, 8'h00, 1'b0, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_stuffing();
        snap_t e, o; string nm;
        do_reset();
        put(8'hFF, "stuff_ff", mk(16'h0000, 6'd0, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h00, "stuff_00", mk(16'hFF00, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h12, "stuff_12", mk(16'hFF12, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_marker();
        snap_t e, o; string nm;
        do_reset();
        put(8'h81, "mk_81", mk(16'h8100, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hFF, "mk_ff", mk(16'h8100, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hFF, "mk_fill", mk(16'h8100, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hD9, "mk_d9", mk(16'h8100, 6'd8, 1'b1, 8'hD9, 1'b0, 1'b0));
        put(8'h77, "mk_blocked", mk(16'h8100, 6'd8, 1'b1, 8'hD9, 1'b0, 1'b0));
        eat(5'd4, "mk_consume", mk(16'h1000, 6'd4, 1'b1, 8'hD9, 1'b0, 1'b0));
        marker_clear = 1'b1;
        consume_en   = 1'b1;
        consume_len  = 5'd31;
        tick("mk_clear_prec", mk(16'h0000, 6'd0, 1'b0, 8'hD9, 1'b0, 1'b1));
        put(8'h7E, "mk_resume", mk(16'h7E00, 6'd8, 1'b0, 8'hD9, 1'b0, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_full();
        snap_t e, o; string nm;
        do_reset();
        put(8'h11, "full_11", mk(16'h1100, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h22, "full_22", mk(16'h1122, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h33, "full_33", mk(16'h1122, 6'd24, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h44, "full_44", mk(16'h1122, 6'd32, 1'b0, 8'h00, 1'b0, 1'b0));
        put(8'h99, "full_not_ready", mk(16'h1122, 6'd32, 1'b0, 8'h00, 1'b0, 1'b0));
        eat(5'd8, "full_consume8", mk(16'h2233, 6'd24, 1'b0, 8'h00, 1'b0, 1'b1));
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        eat(5'd5, "full_consume_and_byte", mk(16'h4668, 6'd27, 1'b0, 8'h00, 1'b0, 1'b0));
        eat(5'd17, "full_len17_illegal", mk(16'h4668, 6'd27, 1'b0, 8'h00, 1'b1, 1'b0));
        eat(5'd16, "full_consume16", mk(16'h8AA0, 6'd11, 1'b0, 8'h00, 1'b1, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_underflow();
        snap_t e, o; string nm;
        do_reset();
        put(8'hC3, "uf_c3", mk(16'hC300, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        eat(5'd9, "uf_consume9", mk(16'hC300, 6'd8, 1'b0, 8'h00, 1'b1, 1'b1));
        eat(5'd8, "uf_consume8", mk(16'h0000, 6'd0, 1'b0, 8'h00, 1'b1, 1'b1));
        eat(5'd0, "uf_consume0_empty", mk(16'h0000, 6'd0, 1'b0, 8'h00, 1'b1, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        snap_t e, o; string nm;
        do_reset();
        put(8'hFF, "rm_ff", mk(16'h0000, 6'd0, 1'b0, 8'h00, 1'b0, 1'b1));
        do_reset();
        put(8'h00, "rm_00_after_reset", mk(16'h0000, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hFF, "rm_ff2", mk(16'h0000, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h45, "rm_marker", mk(16'h0000, 6'd8, 1'b1, 8'h45, 1'b0, 1'b0));
        do_reset();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o; string nm;
        do_reset();
        put(8'h01, "b2b_01", mk(16'h0100, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hFF, "b2b_ff", mk(16'h0100, 6'd8, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h00, "b2b_00", mk(16'h01FF, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hFF, "b2b_ff2", mk(16'h01FF, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'hFF, "b2b_fill", mk(16'h01FF, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h00, "b2b_00b", mk(16'h01FF, 6'd24, 1'b0, 8'h00, 1'b0, 1'b1));
        put(8'h02, "b2b_02", mk(16'h01FF, 6'd32, 1'b0, 8'h00, 1'b0, 1'b0));
        eat(5'd16, "b2b_consume16", mk(16'hFF02, 6'd16, 1'b0, 8'h00, 1'b0, 1'b1));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got peek=%h avail=%0d found=%b code=%h uf=%b ready=%b want peek=%h avail=%0d found=%b code=%h uf=%b ready=%b",
                         nm, o.peek, o.avail, o.found, o.code, o.uf, o.ready, e.peek, e.avail, e.found, e.code, e.uf, e.ready);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        byte_in      = 8'h00;
        byte_valid   = 1'b0;
        consume_en   = 1'b0;
        consume_len  = 5'd0;
        marker_clear = 1'b0;
        test_reset();
        test_basic();
        test_stuffing();
        test_marker();
        test_full();
        test_underflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpeg_bitstream_reader.md
JPEG_BITSTREAM_READER -- requirements
Module: jpeg_bitstream_reader

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 byte_in  input  8  next entropy-coded byte, in stream order.
REQ-005 byte_valid  input  1  byte_in is valid this cycle.
REQ-006 byte_ready  output  1  block accepts byte_in this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-007 peek_bits  output  16  next 16 unconsumed bits, MSB-first, left-aligned; bits beyond bits_avail read 0.
REQ-008 bits_avail  output  6  count of valid unconsumed bits, range 0..32.
REQ-009 consume_en  input  1  request to discard bits from the head of the buffer.
REQ-010 consume_len  input  5  number of bits to discard; legal range 0..16.
REQ-011 marker_clear  input  1  acknowledge a detected marker and resume.
REQ-012 marker_found  output  1  a non-stuffed 0xFF-xx marker has been detected.
REQ-013 marker_code  output  8  second byte of the detected marker.
REQ-014 underflow  output  1  sticky flag for an illegal consume request.

Function
REQ-015 The block SHALL hold a 32-bit left-aligned bit buffer plus a 6-bit count, with states RUN, FF_SEEN and MARKER.
REQ-016 byte_ready SHALL be (bits_avail <= 24) && state != MARKER && !reset, as a combinational function of registered state.
REQ-017 In RUN, an accepted byte other than 0xFF SHALL be appended immediately after the existing valid bits (count += 8).
REQ-018 In RUN, an accepted 0xFF SHALL append nothing and move the state to FF_SEEN.
REQ-019 In FF_SEEN, an accepted 0x00 SHALL append 0xFF (count += 8) and return the state to RUN.
REQ-020 In FF_SEEN, an accepted 0xFF SHALL be treated as a fill byte: nothing is appended and the state stays FF_SEEN.
REQ-021 In FF_SEEN, an accepted byte other than 0x00 or 0xFF SHALL append nothing, set marker_code to that byte, set marker_found=1 and move the state to MARKER.
REQ-022 In MARKER, byte_ready SHALL be 0; buffered bits remain consumable.
REQ-023 marker_clear in MARKER SHALL zero the buffer and count, clear marker_found, return the state to RUN and leave marker_code unchanged.
REQ-024 marker_clear outside MARKER SHALL be ignored.
REQ-025 A legal consume SHALL shift the buffer left by consume_len with zero fill and set count -= consume_len.
  - Legal means consume_en=1, consume_len <= 16 and consume_len <= bits_avail.
REQ-026 consume_en with consume_len = 0 SHALL be a no-op.
REQ-027 An illegal consume SHALL leave the buffer and count unchanged and set underflow=1.
  - Illegal means consume_en=1 with consume_len > bits_avail or consume_len > 16.
  - underflow is cleared only by reset.
REQ-028 A consume and a byte acceptance in the same cycle SHALL both take effect.
  - The shift is applied first; the appended bits land after the remaining bits.
  - Resulting count = count - consume_len + 8 (never exceeds 32).
REQ-029 When marker_clear and consume_en occur together in MARKER, marker_clear SHALL take precedence and the consume SHALL be ignored, including for underflow.
REQ-030 peek_bits, bits_avail, marker_found, marker_code and underflow SHALL be registered.
  - A byte accepted or bits consumed at edge N are reflected at these outputs from edge N onward, i.e. one-cycle latency.
REQ-031 Bit order SHALL match the encoder's jpeg_out: the MSB of each byte is the first bit of the stream.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL load the following, and no byte or consume is taken in that cycle:
  - buffer=0, bits_avail=0, state=RUN
  - marker_found=0, marker_code=0x00, underflow=0
REQ-033 A reset asserted mid-operation, including in FF_SEEN or MARKER, SHALL discard all buffered bits and any pending 0xFF.

Verification
REQ-034 Bytes 0xA5, 0x3C, then consume 4 -> after the bytes peek=0xA53C, bits_avail=16; after the consume peek=0x53C0, bits_avail=12.
REQ-035 Bytes 0xFF, 0x00, 0x12 -> peek=0xFF12, bits_avail=16, marker_found=0.
REQ-036 Byte 0x81, then 0xFF, 0xFF, 0xD9 -> marker_found=1, marker_code=0xD9, byte_ready=0, bits_avail=8, peek=0x8100; then marker_clear -> bits_avail=0, byte_ready=1, marker_found=0.
REQ-037 Bytes 0x11, 0x22, 0x33, 0x44:
  - after all four: bits_avail=32, byte_ready=0.
  - consume 8 -> bits_avail=24.
  - consume 5 with byte 0x55 accepted in the same cycle -> bits_avail=27, peek=0x4668.
REQ-038 Byte 0xC3, then consume 9 -> underflow=1, bits_avail=8, peek=0xC300; a later legal consume 8 -> bits_avail=0 and underflow stays 1.
REQ-039 Byte 0xFF, reset pulse, then byte 0x00 -> bits_avail=8, peek=0x0000, marker_found=0.
